// File: rtl/uart_rx_wb.sv
// Wishbone-attached 8N1 UART receiver with a small RX FIFO, sticky error flags
// and a level interrupt.
module uart_rx_wb #(
    parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
    parameter logic [15:0] CLKS_PER_BIT_RST = 16'd4167,
    parameter int          FIFO_DEPTH       = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        rx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic          r_rx_meta;
    logic          r_rxs;
    logic [15:0]   r_div;
    logic          r_irq_en;
    state_t        r_state;
    logic [15:0]   r_cnt;
    logic [15:0]   r_d_lat;
    logic [2:0]    r_bi;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovr;
    logic          r_ferr;
    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_irq;

    logic          w_sel_blk;
    logic          w_req;
    logic          w_rd;
    logic          w_wr;
    logic [1:0]    w_reg;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_stop_hit;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovr_set;
    logic          w_ferr_set;
    logic [CW-1:0] w_count_nxt;
    logic          w_st_wr;
    logic          w_ovr_nxt;
    logic          w_ferr_nxt;
    logic          w_ctrl_wr;
    logic [15:0]   w_div_m;
    logic [15:0]   w_div_nxt;
    logic          w_irq_en_nxt;
    logic          w_irq_nxt;
    logic [31:0]   w_cnt_ext;
    logic [31:0]   w_rdata;
    logic [7:0]    w_head;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_sel_blk  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_req      = wbs_cyc_i & wbs_stb_i & w_sel_blk & ~r_ack;
    assign w_rd       = w_req & ~wbs_we_i;
    assign w_wr       = w_req & wbs_we_i;
    assign w_reg      = wbs_adr_i[3:2];
    assign w_empty    = (r_count == {CW{1'b0}});
    assign w_full     = (r_count == FULL_CNT);
    assign w_stop_hit = (r_state == ST_STOP) && (r_cnt == (r_d_lat - 16'd1));
    assign w_cnt_ext  = 32'(r_count);

    // Next-state decode for FIFO occupancy, sticky flags, CTRL and read data.
    always_comb begin
        w_pop        = 1'b0;
        w_push_req   = 1'b0;
        w_push       = 1'b0;
        w_ovr_set    = 1'b0;
        w_ferr_set   = 1'b0;
        w_count_nxt  = r_count;
        w_st_wr      = 1'b0;
        w_ctrl_wr    = 1'b0;
        w_div_m      = r_div;
        w_div_nxt    = r_div;
        w_irq_en_nxt = r_irq_en;
        w_rdata      = 32'd0;

        w_pop      = w_rd & (w_reg == 2'd0) & ~w_empty;
        w_push_req = w_stop_hit & r_rxs;
        w_ferr_set = w_stop_hit & ~r_rxs;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        w_push     = w_push_req & (~w_full | w_pop);
        w_ovr_set  = w_push_req & w_full & ~w_pop;

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase

        w_st_wr   = w_wr & (w_reg == 2'd1) & wbs_sel_i[0];
        w_ctrl_wr = w_wr & (w_reg == 2'd2);

        if (wbs_sel_i[0]) begin
            w_div_m[7:0] = wbs_dat_i[7:0];
        end else begin
            w_div_m[7:0] = r_div[7:0];
        end
        if (wbs_sel_i[1]) begin
            w_div_m[15:8] = wbs_dat_i[15:8];
        end else begin
            w_div_m[15:8] = r_div[15:8];
        end

        if (w_ctrl_wr) begin
            if (w_div_m < 16'd4) begin
                w_div_nxt = 16'd4;
            end else begin
                w_div_nxt = w_div_m;
            end
            if (wbs_sel_i[2]) begin
                w_irq_en_nxt = wbs_dat_i[16];
            end else begin
                w_irq_en_nxt = r_irq_en;
            end
        end else begin
            w_div_nxt    = r_div;
            w_irq_en_nxt = r_irq_en;
        end

        case (w_reg)
            2'd0: begin
                if (w_empty) begin
                    w_rdata = 32'd0;
                end else begin
                    w_rdata = {24'd0, w_head};
                end
            end
            2'd1:    w_rdata = {24'd0, w_cnt_ext[3:0], r_ferr, r_ovr, w_full, ~w_empty};
            2'd2:    w_rdata = {15'd0, r_irq_en, r_div};
            default: w_rdata = 32'd0;
        endcase
    end

    // Set wins over a simultaneous W1C clear.
    assign w_ovr_nxt  = w_ovr_set  | (r_ovr  & ~(w_st_wr & wbs_dat_i[2]));
    assign w_ferr_nxt = w_ferr_set | (r_ferr & ~(w_st_wr & wbs_dat_i[3]));
    assign w_irq_nxt  = w_irq_en_nxt &
                        ((w_count_nxt != {CW{1'b0}}) | w_ovr_nxt | w_ferr_nxt);

    // Two-stage synchronizer for the asynchronous serial input.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Control/status registers, bus response and interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_div    <= CLKS_PER_BIT_RST;
            r_irq_en <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_irq    <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            r_irq_en <= w_irq_en_nxt;
            r_ovr    <= w_ovr_nxt;
            r_ferr   <= w_ferr_nxt;
            r_ack    <= w_req;
            r_dat    <= w_rd ? w_rdata : 32'd0;
            r_irq    <= w_irq_nxt;
        end
    end

    // FIFO storage is left unreset; emptiness comes from the pointers and count.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_nxt;
        end
    end

    // Receive FSM; the detect cycle itself counts as the first start-bit cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_d_lat <= 16'd4;
            r_bi    <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rxs) begin
                        r_d_lat <= r_div;
                        r_cnt   <= 16'd1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == (r_d_lat >> 1)) begin
                        r_cnt <= 16'd0;
                        r_bi  <= 3'd0;
                        if (!r_rxs) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == (r_d_lat - 16'd1)) begin
                        r_shift[r_bi] <= r_rxs;
                        r_cnt         <= 16'd0;
                        if (r_bi == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bi <= r_bi + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_stop_hit) begin
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_cnt   <= 16'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq       = r_irq;

endmodule

// File: tb/tb_uart_rx_wb.sv
// Directed bench for uart_rx_wb: serial frames in, Wishbone register reads out.
module tb_uart_rx_wb;

    localparam logic [31:0] A_RX   = 32'h3000_0000;
    localparam logic [31:0] A_ST   = 32'h3000_0004;
    localparam logic [31:0] A_CTRL = 32'h3000_0008;
    localparam logic [31:0] A_RES  = 32'h3000_000C;
    localparam int          BIT_D  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0;
    logic [31:0] wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic        rx = 1'b1;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] d;
    logic        a;

    uart_rx_wb dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .rx       (rx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_read(input logic [31:0] ad, output logic [31:0] dv, output logic av);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = ad;
        @(posedge clk);
        #1;
        av = ack;
        dv = rdat;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] ad, input logic [31:0] dv, input logic [3:0] sv);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = sv; adr = ad; wdat = dv;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] ad, input logic [31:0] exp);
        logic [31:0] dv;
        logic        av;
        wb_read(ad, dv, av);
        check({tag, "_ack"}, {31'd0, av}, 32'd1);
        check(tag, dv, exp);
    endtask

    // Drives one frame starting at the current negedge; returns on a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stopb);
        rx = 1'b0;
        repeat (BIT_D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_D) @(negedge clk);
        end
        rx = stopb;
        repeat (BIT_D) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        rd_chk("rst_status", A_ST, 32'h0000_0000);
        rd_chk("rst_ctrl", A_CTRL, 32'h0000_1047);
        rd_chk("rx_empty", A_RX, 32'h0000_0000);
        rd_chk("reserved", A_RES, 32'h0000_0000);
        wb_read(32'h3000_0010, d, a);
        check("unsel_ack", {31'd0, a}, 32'd0);
        @(posedge clk); #1;
        check("unsel_ack2", {31'd0, ack}, 32'd0);
        check("idle_dat", rdat, 32'd0);

        wb_write(A_CTRL, 32'h0001_0010, 4'hF);
        rd_chk("ctrl_16", A_CTRL, 32'h0001_0010);

        // Single byte with interrupt latency: stop sample lands on the 155th edge.
        fork
            send_frame(8'h3D, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 check("irq_before", {31'd0, irq}, 32'd0);
                @(posedge clk);
                #1 check("irq_rise", {31'd0, irq}, 32'd1);
            end
        join
        rd_chk("st_one", A_ST, 32'h0000_0011);
        rd_chk("rx_3d", A_RX, 32'h0000_003D);
        check("irq_drop", {31'd0, irq}, 32'd0);
        rd_chk("st_after_pop", A_ST, 32'h0000_0000);

        // Overrun with five back-to-back frames.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        rd_chk("st_ovr", A_ST, 32'h0000_0047);
        for (int i = 1; i <= 4; i++) rd_chk("rx_ovr_seq", A_RX, 32'(i));
        rd_chk("st_ovr_empty", A_ST, 32'h0000_0004);
        check("irq_ovr", {31'd0, irq}, 32'd1);
        wb_write(A_ST, 32'h0000_0004, 4'hF);
        rd_chk("st_ovr_clr", A_ST, 32'h0000_0000);
        check("irq_ovr_clr", {31'd0, irq}, 32'd0);

        // Frame error, W1C lane gating, then a clean byte.
        send_frame(8'h55, 1'b0);
        repeat (3 * BIT_D) @(negedge clk);
        rd_chk("st_ferr", A_ST, 32'h0000_0008);
        check("irq_ferr", {31'd0, irq}, 32'd1);
        wb_write(A_ST, 32'h0000_0008, 4'b0010);
        rd_chk("st_ferr_nosel", A_ST, 32'h0000_0008);
        wb_write(A_ST, 32'h0000_0008, 4'hF);
        rd_chk("st_ferr_clr", A_ST, 32'h0000_0000);
        send_frame(8'hA5, 1'b1);
        rd_chk("rx_a5", A_RX, 32'h0000_00A5);

        // False start of D/4 cycles.
        rx = 1'b0;
        repeat (BIT_D / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_D) @(negedge clk);
        rd_chk("st_glitch", A_ST, 32'h0000_0000);

        wb_write(A_CTRL, 32'h0001_0002, 4'hF);
        rd_chk("ctrl_min4", A_CTRL, 32'h0001_0004);
        wb_write(A_CTRL, 32'h0001_0010, 4'hF);

        // Divider change mid-frame through byte lane 0 only.
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (40) @(posedge clk);
                wb_write(A_CTRL, 32'h0000_FF20, 4'b0001);
            end
        join
        rd_chk("rx_96", A_RX, 32'h0000_0096);
        rd_chk("ctrl_lane", A_CTRL, 32'h0001_0020);
        wb_write(A_CTRL, 32'h0000_0010, 4'b0001);
        rd_chk("ctrl_restore", A_CTRL, 32'h0001_0010);

        // Fill, then pop in the exact push cycle of the fifth byte.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        fork
            send_frame(8'h15, 1'b1);
            begin
                repeat (154) @(posedge clk);
                wb_read(A_RX, d, a);
            end
        join
        check("pp_ack", {31'd0, a}, 32'd1);
        check("pp_data", d, 32'h0000_0011);
        rd_chk("st_pp", A_ST, 32'h0000_0043);
        for (int i = 0; i < 4; i++) rd_chk("rx_pp_seq", A_RX, 32'h12 + 32'(i));
        rd_chk("st_pp_empty", A_ST, 32'h0000_0000);

        // Reset during bit 3 with a byte pending.
        send_frame(8'h77, 1'b1);
        check("irq_pending", {31'd0, irq}, 32'd1);
        fork
            send_frame(8'hF8, 1'b1);
            begin
                repeat (70) @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                check("mid_rst_ack", {31'd0, ack}, 32'd0);
                check("mid_rst_dat", rdat, 32'd0);
                check("mid_rst_irq", {31'd0, irq}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (2 * BIT_D) @(negedge clk);
        rd_chk("st_post_rst", A_ST, 32'h0000_0000);
        rd_chk("ctrl_post_rst", A_CTRL, 32'h0000_1047);
        wb_write(A_CTRL, 32'h0001_0010, 4'hF);
        send_frame(8'h5A, 1'b1);
        rd_chk("st_5a", A_ST, 32'h0000_0011);
        rd_chk("rx_5a", A_RX, 32'h0000_005A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
